// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access unit and its control FSM.
package lc3_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

  // LC-3 memory opcodes; the control FSM derives req_write/req_indirect from these.
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;

  function automatic logic op_is_write(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STI);
  endfunction

  function automatic logic op_is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Word-addressed single-port memory: combinational read, synchronous write, no reset.
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/lc3_mem_unit.sv
// Multi-cycle LC-3 memory access unit with wait states and LDI/STI pointer dereference.
// Optional bounds fault on addresses >= DEPTH when LC3_MEM_BOUNDS_CHECK_EN is defined.
module lc3_mem_unit
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 2**ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_indirect,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_ok;
  logic [IDX_W-1:0]  mem_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) % DEPTH);
  endfunction

  // The single memory port reads the pointer location in PTR and the effective address otherwise.
  assign cur_addr = (state_q == PTR) ? addr_q : ea_q;
  assign mem_idx  = to_index(cur_addr);

`ifdef LC3_MEM_BOUNDS_CHECK_EN
  assign cur_ok = (32'(cur_addr) < DEPTH);
`else
  assign cur_ok = 1'b1;
`endif

  lc3_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_idx),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ea_d    = ea_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          ea_d    = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          cnt_d   = CNT_LOAD;
          err_d   = 1'b0;
          state_d = req_indirect ? PTR : ACCESS;
        end
      end
      PTR: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (cur_ok) begin
            ea_d    = mem_rdata[ADDR_W-1:0];
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (cur_ok) begin
            if (write_q) begin
              mem_we  = 1'b1;
              rdata_d = wdata_q;
            end else begin
              rdata_d = mem_rdata;
            end
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ea_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ea_q    <= ea_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Ready is masked by rst so the requester never sees a handshake during reset.
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Scoreboard bench for lc3_mem_unit: WAIT_CYCLES=2 instance (a) and WAIT_CYCLES=0 instance (b).
module tb_lc3_mem_unit;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_valid, a_ready, a_write, a_ind, a_rv, a_err, a_busy;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_ready, b_write, b_ind, b_rv, b_err, b_busy;
  logic [15:0] b_addr, b_wdata, b_rdata;

  always #5 clk = ~clk;

  lc3_mem_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_indirect(a_ind), .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy)
  );

  lc3_mem_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_indirect(b_ind), .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy)
  );

  // Drives a request and holds it until the accepting edge; returns at accept edge + 1.
  task automatic send(input bit sel, input logic wr, input logic ind,
                      input logic [15:0] addr, input logic [15:0] wdata);
    bit rdy;
    if (sel) begin
      b_valid = 1'b1; b_write = wr; b_ind = ind; b_addr = addr; b_wdata = wdata;
    end else begin
      a_valid = 1'b1; a_write = wr; a_ind = ind; a_addr = addr; a_wdata = wdata;
    end
    for (int i = 0; i < 20; i++) begin
      rdy = sel ? b_ready : a_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_addr  = 16'hFFFF;
    b_addr  = 16'hFFFF;
  endtask

  // Counts edges until resp_valid; lat stays -1 if the budget expires.
  task automatic wait_resp(input bit sel, output int lat, output logic [15:0] rd,
                           output logic er, output logic allbusy);
    lat = -1; rd = 'x; er = 'x; allbusy = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      allbusy &= (sel ? b_busy : a_busy);
      if (sel ? b_rv : a_rv) begin
        lat = n;
        rd  = sel ? b_rdata : a_rdata;
        er  = sel ? b_err : a_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", a_ready); end
    checks++; if (a_rv !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", a_rv); end
    checks++; if (a_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0000", a_rdata); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", a_err); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", a_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b want 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready_b got %b want 1", b_ready); end
  endtask

  task automatic test_direct_load;
    int lat; logic [15:0] rd; logic er, bz; sb_t e;
    u_dut_a.u_array.mem[11] = 16'd12;
    sbq.push_back('{rdata: 16'h000C, err: 1'b0, lat: 3});
    send(0, 1'b0, 1'b0, 16'd11, 16'h0000);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL ld_latency got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin errors++; $display("[TB] FAIL ld_rdata got %h want %h", rd, e.rdata); end
    checks++; if (er !== e.err) begin errors++; $display("[TB] FAIL ld_err got %b want %b", er, e.err); end
    @(posedge clk); #1;
    checks++; if (a_rv !== 1'b0) begin errors++; $display("[TB] FAIL ld_pulse_width got %b want 0", a_rv); end
  endtask

  task automatic test_indirect_load;
    int lat; logic [15:0] rd; logic er, bz; sb_t e;
    u_dut_a.u_array.mem[10] = 16'd12;
    u_dut_a.u_array.mem[12] = 16'hFC17;
    sbq.push_back('{rdata: 16'hFC17, err: 1'b0, lat: 6});
    send(0, 1'b0, 1'b1, 16'd10, 16'h0000);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL ldi_latency got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin errors++; $display("[TB] FAIL ldi_rdata got %h want %h", rd, e.rdata); end
    checks++; if (er !== e.err) begin errors++; $display("[TB] FAIL ldi_err got %b want %b", er, e.err); end
    checks++; if (bz !== 1'b1) begin errors++; $display("[TB] FAIL ldi_busy got %b want 1", bz); end
    @(posedge clk); #1;
  endtask

  task automatic test_indirect_store;
    int lat; logic [15:0] rd; logic er, bz; sb_t e;
    u_dut_a.u_array.mem[13] = 16'd11;
    sbq.push_back('{rdata: 16'h1234, err: 1'b0, lat: 6});
    send(0, 1'b1, 1'b1, 16'd13, 16'h1234);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL sti_latency got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin errors++; $display("[TB] FAIL sti_echo got %h want %h", rd, e.rdata); end
    checks++; if (u_dut_a.u_array.mem[11] !== 16'h1234) begin errors++; $display("[TB] FAIL sti_target got %h want 1234", u_dut_a.u_array.mem[11]); end
    checks++; if (u_dut_a.u_array.mem[13] !== 16'd11) begin errors++; $display("[TB] FAIL sti_pointer got %h want 000b", u_dut_a.u_array.mem[13]); end
    @(posedge clk); #1;
    // Store through a pointer that points at itself: pointer used first, then overwritten.
    u_dut_a.u_array.mem[14] = 16'd14;
    sbq.push_back('{rdata: 16'h00AA, err: 1'b0, lat: 6});
    send(0, 1'b1, 1'b1, 16'd14, 16'h00AA);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (rd !== e.rdata || lat !== e.lat) begin errors++; $display("[TB] FAIL sti_self got %h/%0d want %h/%0d", rd, lat, e.rdata, e.lat); end
    checks++; if (u_dut_a.u_array.mem[14] !== 16'h00AA) begin errors++; $display("[TB] FAIL sti_self_mem got %h want 00aa", u_dut_a.u_array.mem[14]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd; logic er, bz; sb_t e;
    u_dut_b.u_array.mem[5] = 16'h0000;
    sbq.push_back('{rdata: 16'hBEEF, err: 1'b0, lat: 1});
    send(1, 1'b1, 1'b0, 16'd5, 16'hBEEF);
    wait_resp(1, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat || rd !== e.rdata) begin errors++; $display("[TB] FAIL b2b_store got %h/%0d want %h/%0d", rd, lat, e.rdata, e.lat); end
    checks++; if (er !== e.err) begin errors++; $display("[TB] FAIL b2b_store_err got %b want %b", er, e.err); end
    @(posedge clk); #1;
    checks++; if (b_rv !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap got valid=%b ready=%b want 0/1", b_rv, b_ready); end
    sbq.push_back('{rdata: 16'hBEEF, err: 1'b0, lat: 1});
    send(1, 1'b0, 1'b0, 16'd5, 16'h0000);
    wait_resp(1, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL b2b_load_latency got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin errors++; $display("[TB] FAIL b2b_load_rdata got %h want %h", rd, e.rdata); end
    @(posedge clk); #1;
    checks++; if (b_rv !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pulse_width got %b want 0", b_rv); end
  endtask

  task automatic test_reset_mid_store;
    u_dut_a.u_array.mem[20] = 16'h5555;
    send(0, 1'b1, 1'b0, 16'd20, 16'hAAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0 || a_rv !== 1'b0) begin errors++; $display("[TB] FAIL midrst_state got busy=%b valid=%b want 0/0", a_busy, a_rv); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready got %b want 0", a_ready); end
    checks++; if (a_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_rdata got %h want 0000", a_rdata); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (u_dut_a.u_array.mem[20] !== 16'h5555) begin errors++; $display("[TB] FAIL midrst_mem got %h want 5555", u_dut_a.u_array.mem[20]); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_release_ready got %b want 1", a_ready); end
  endtask

  task automatic test_bounds;
    int lat; logic [15:0] rd; logic er, bz; sb_t e;
    u_dut_a.u_array.mem[44] = 16'h2C2C;
    u_dut_a.u_array.mem[45] = 16'h1111;
    u_dut_a.u_array.mem[16] = 16'd300;
`ifdef LC3_MEM_BOUNDS_CHECK_EN
    sbq.push_back('{rdata: 16'h0000, err: 1'b1, lat: 3});
    sbq.push_back('{rdata: 16'h0000, err: 1'b1, lat: 3});
    sbq.push_back('{rdata: 16'h0000, err: 1'b1, lat: 6});
`else
    sbq.push_back('{rdata: 16'h2C2C, err: 1'b0, lat: 3});
    sbq.push_back('{rdata: 16'h9999, err: 1'b0, lat: 3});
    sbq.push_back('{rdata: 16'h2C2C, err: 1'b0, lat: 6});
`endif
    send(0, 1'b0, 1'b0, 16'd300, 16'h0000);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL oob_ld_latency got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL oob_ld got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    @(posedge clk); #1;
    send(0, 1'b1, 1'b0, 16'd301, 16'h9999);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL oob_st got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
`ifdef LC3_MEM_BOUNDS_CHECK_EN
    checks++; if (u_dut_a.u_array.mem[45] !== 16'h1111) begin errors++; $display("[TB] FAIL oob_st_mem got %h want 1111", u_dut_a.u_array.mem[45]); end
`else
    checks++; if (u_dut_a.u_array.mem[45] !== 16'h9999) begin errors++; $display("[TB] FAIL oob_st_mem got %h want 9999", u_dut_a.u_array.mem[45]); end
`endif
    @(posedge clk); #1;
    send(0, 1'b0, 1'b1, 16'd16, 16'h0000);
    wait_resp(0, lat, rd, er, bz);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL oob_ptr got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
    @(posedge clk); #1;
    send(0, 1'b0, 1'b0, 16'd11, 16'h0000);
    wait_resp(0, lat, rd, er, bz);
    checks++; if (er !== 1'b0 || rd !== 16'h1234) begin errors++; $display("[TB] FAIL err_clear got %h/%b want 1234/0", rd, er); end
    @(posedge clk); #1;
  endtask

  initial begin
    a_valid = 1'b0; a_write = 1'b0; a_ind = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_ind = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_direct_load();
    test_indirect_load();
    test_indirect_store();
    test_back_to_back();
    test_reset_mid_store();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
